// File: rtl/ft_alu_pkg.sv
// Shared types and constants for the fault-tolerant ALU controller.
// The optional fault counter is enabled with FT_ALU_CTRL_FAULT_CNT_EN.
package ft_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_AMB = 2'd1,
    OP_BMA = 2'd2,
    OP_ILL = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CHECK,
    S_RESP
  } state_e;

  localparam logic [2:0] OH_ADD  = 3'b001;
  localparam logic [2:0] OH_AMB  = 3'b010;
  localparam logic [2:0] OH_BMA  = 3'b100;
  localparam logic [1:0] RAIL_OK = 2'b10;

  function automatic logic [2:0] op_onehot(input op_e op);
    case (op)
      OP_AMB:  return OH_AMB;
      OP_BMA:  return OH_BMA;
      default: return OH_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ft_alu_ctrl_arb.sv
// Two-input round-robin arbiter; the pointer moves past the requester
// just served when adv_i is pulsed.
module ft_alu_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o,
  input  logic       adv_i,
  input  logic       adv_id_i
);

  logic prio_q, prio_d;

  always_comb begin
    gnt_id_o = prio_q;
    if (!req_i[prio_q]) gnt_id_o = ~prio_q;
    gnt_o = 2'b00;
    if (en_i && (|req_i)) gnt_o = 2'b01 << gnt_id_o;
    prio_d = adv_i ? ~adv_id_i : prio_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end

endmodule

// File: rtl/ft_alu_ctrl.sv
// Arbitrates two requesters onto the duplicated ALU, checks both result
// rails and retries on mismatch. Define FT_ALU_CTRL_FAULT_CNT_EN for fault_cnt_o.
module ft_alu_ctrl
  import ft_alu_pkg::*;
#(
  parameter int SETTLE_CYC = 1,
  parameter int MAX_RETRY  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid_i,
  output logic [1:0]      req_ready_o,
  input  logic [1:0][1:0] req_op_i,
  input  logic [1:0][2:0] req_a_i,
  input  logic [1:0][2:0] req_b_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic            rsp_id_o,
  output logic [2:0]      rsp_sum_o,
  output logic            rsp_carry_o,
  output logic            rsp_err_o,
  output logic [2:0]      alu_a_o,
  output logic [2:0]      alu_b_o,
  output logic            alu_par_o,
  output logic [2:0]      alu_c_o,
  input  logic [2:0]      alu_x_i,
  input  logic [2:0]      alu_y_i,
  input  logic            alu_xc_i,
  input  logic            alu_yc_i,
  input  logic [1:0]      alu_xe_i,
  input  logic [1:0]      alu_ye_i,
  output logic            busy_o
`ifdef FT_ALU_CTRL_FAULT_CNT_EN
  ,
  output logic [7:0]      fault_cnt_o,
  input  logic            fault_clr_i
`endif
);

  localparam logic [2:0] SettleInit = 3'(SETTLE_CYC);
  localparam logic [2:0] MaxRetry   = 3'(MAX_RETRY);

  state_e     state_q, state_d;
  logic [2:0] settle_q, settle_d, retry_q, retry_d;
  logic [2:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_c_q, alu_c_d;
  logic       alu_par_q, alu_par_d;
  logic       rsp_id_q, rsp_id_d, rsp_carry_q, rsp_carry_d, rsp_err_q, rsp_err_d;
  logic [2:0] rsp_sum_q, rsp_sum_d;
  logic [1:0] gnt;
  logic       gnt_id, adv, check_pass;
  op_e        gnt_op;

  ft_alu_rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_valid_i),
    .en_i     (state_q == S_IDLE),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .adv_i    (adv),
    .adv_id_i (rsp_id_q)
  );

  assign gnt_op     = op_e'(req_op_i[gnt_id]);
  assign check_pass = (alu_x_i == alu_y_i) && (alu_xc_i == alu_yc_i) &&
                      (alu_xe_i == RAIL_OK) && (alu_ye_i == RAIL_OK);

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    retry_d     = retry_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_c_d     = alu_c_q;
    alu_par_d   = alu_par_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    rsp_err_d   = rsp_err_q;
    adv         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|gnt) begin
          rsp_id_d = gnt_id;
          // Illegal opcodes never reach the ALU pins.
          if (gnt_op == OP_ILL) begin
            rsp_err_d   = 1'b1;
            rsp_sum_d   = 3'd0;
            rsp_carry_d = 1'b0;
            state_d     = S_RESP;
          end else begin
            alu_a_d   = req_a_i[gnt_id];
            alu_b_d   = req_b_i[gnt_id];
            alu_par_d = ~((^req_a_i[gnt_id]) ^ (^req_b_i[gnt_id]));
            alu_c_d   = op_onehot(gnt_op);
            settle_d  = SettleInit;
            retry_d   = 3'd0;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        settle_d = settle_q - 3'd1;
        if (settle_q == 3'd1) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (check_pass) begin
          rsp_sum_d   = alu_x_i;
          rsp_carry_d = alu_xc_i;
          rsp_err_d   = 1'b0;
          state_d     = S_RESP;
        end else if (retry_q < MaxRetry) begin
          retry_d  = retry_q + 3'd1;
          settle_d = SettleInit;
          state_d  = S_ISSUE;
        end else begin
          rsp_sum_d   = alu_x_i;
          rsp_carry_d = alu_xc_i;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          adv     = 1'b1;
          alu_c_d = OH_ADD;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      settle_q    <= 3'd0;
      retry_q     <= 3'd0;
      alu_a_q     <= 3'd0;
      alu_b_q     <= 3'd0;
      alu_c_q     <= OH_ADD;
      alu_par_q   <= 1'b1;
      rsp_id_q    <= 1'b0;
      rsp_sum_q   <= 3'd0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      retry_q     <= retry_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_c_q     <= alu_c_d;
      alu_par_q   <= alu_par_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready_o = gnt;
  assign rsp_valid_o = (state_q == S_RESP);
  assign busy_o      = (state_q != S_IDLE);
  assign rsp_id_o    = rsp_id_q;
  assign rsp_sum_o   = rsp_sum_q;
  assign rsp_carry_o = rsp_carry_q;
  assign rsp_err_o   = rsp_err_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_c_o     = alu_c_q;
  assign alu_par_o   = alu_par_q;

`ifdef FT_ALU_CTRL_FAULT_CNT_EN
  logic [7:0] fault_cnt_q;

  // Clear wins over a coincident failed check; the count saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              fault_cnt_q <= 8'd0;
    else if (fault_clr_i) fault_cnt_q <= 8'd0;
    else if ((state_q == S_CHECK) && !check_pass && (fault_cnt_q != 8'hFF))
      fault_cnt_q <= fault_cnt_q + 8'd1;
  end

  assign fault_cnt_o = fault_cnt_q;
`endif

endmodule

// File: tb/tb_ft_alu_ctrl.sv
// Self-checking bench for ft_alu_ctrl: table-driven vectors, a response
// scoreboard and hand-written retry/reset sequences.
module tb_ft_alu_ctrl;

  localparam int SETTLE = 1;
  localparam int MAXR   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      reqValid, reqReady;
  logic [1:0][1:0] reqOp;
  logic [1:0][2:0] reqA, reqB;
  logic            rspValid, rspReady, rspId, rspCarry, rspErr;
  logic [2:0]      rspSum;
  logic [2:0]      aluA, aluB, aluC, aluX, aluY;
  logic            aluPar, aluXc, aluYc, busy;
  logic [1:0]      aluXe, aluYe;
`ifdef FT_ALU_CTRL_FAULT_CNT_EN
  logic [7:0]      faultCnt;
  logic            faultClr = 1'b0;
`endif

  logic xeFault    = 1'b0;
  logic xyMismatch = 1'b0;
  int   checks     = 0;
  int   fails      = 0;

  typedef struct {
    logic       id;
    logic [1:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] expSum;
    logic       expCarry;
    logic       expErr;
    logic [2:0] expC;
    logic       expPar;
  } vec_t;

  typedef struct {
    logic       id;
    logic [2:0] sum;
    logic       carry;
    logic       err;
  } rsp_t;

  rsp_t sbQ[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  ft_alu_ctrl #(.SETTLE_CYC(SETTLE), .MAX_RETRY(MAXR)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (reqValid),
    .req_ready_o (reqReady),
    .req_op_i    (reqOp),
    .req_a_i     (reqA),
    .req_b_i     (reqB),
    .rsp_valid_o (rspValid),
    .rsp_ready_i (rspReady),
    .rsp_id_o    (rspId),
    .rsp_sum_o   (rspSum),
    .rsp_carry_o (rspCarry),
    .rsp_err_o   (rspErr),
    .alu_a_o     (aluA),
    .alu_b_o     (aluB),
    .alu_par_o   (aluPar),
    .alu_c_o     (aluC),
    .alu_x_i     (aluX),
    .alu_y_i     (aluY),
    .alu_xc_i    (aluXc),
    .alu_yc_i    (aluYc),
    .alu_xe_i    (aluXe),
    .alu_ye_i    (aluYe),
    .busy_o      (busy)
`ifdef FT_ALU_CTRL_FAULT_CNT_EN
    ,
    .fault_cnt_o (faultCnt),
    .fault_clr_i (faultClr)
`endif
  );

  // Behavioural duplicated ALU with injectable rail and channel faults.
  always_comb begin
    logic [3:0] r;
    r = 4'd0;
    case (aluC)
      3'b001:  r = {1'b0, aluA} + {1'b0, aluB};
      3'b010:  r = {1'b0, aluA} + {1'b0, ~aluB} + 4'd1;
      3'b100:  r = {1'b0, aluB} + {1'b0, ~aluA} + 4'd1;
      default: r = 4'd0;
    endcase
    aluX  = r[2:0];
    aluXc = r[3];
    aluY  = xyMismatch ? (r[2:0] ^ 3'b001) : r[2:0];
    aluYc = r[3];
    aluXe = xeFault ? 2'b11 : 2'b10;
    aluYe = 2'b10;
  end

  task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    rsp_t e;
    if (sbQ.size() == 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL unexpected_rsp: got id=%0d sum=%0d expected no response", rspId, rspSum);
    end else begin
      e = sbQ.pop_front();
      checkValue("rsp_id", rspId, e.id);
      checkValue("rsp_sum", rspSum, e.sum);
      checkValue("rsp_carry", rspCarry, e.carry);
      checkValue("rsp_err", rspErr, e.err);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (rst === 1'b0 && rspValid === 1'b1 && rspReady === 1'b1) checkOutput();
  end

  task automatic checkResetValues();
    checkValue("rst_req_ready", reqReady, 0);
    checkValue("rst_rsp_valid", rspValid, 0);
    checkValue("rst_rsp_id", rspId, 0);
    checkValue("rst_rsp_sum", rspSum, 0);
    checkValue("rst_rsp_carry", rspCarry, 0);
    checkValue("rst_rsp_err", rspErr, 0);
    checkValue("rst_busy", busy, 0);
    checkValue("rst_alu_a", aluA, 0);
    checkValue("rst_alu_b", aluB, 0);
    checkValue("rst_alu_par", aluPar, 1);
    checkValue("rst_alu_c", aluC, 3'b001);
`ifdef FT_ALU_CTRL_FAULT_CNT_EN
    checkValue("rst_fault_cnt", faultCnt, 0);
`endif
  endtask

  // Returns at the first falling edge after the accepting rising edge.
  task automatic acceptReq(input logic id, input logic [1:0] op, input logic [2:0] a,
                           input logic [2:0] b, input rsp_t exp);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    reqValid[id] = 1'b1;
    reqOp[id]    = op;
    reqA[id]     = a;
    reqB[id]     = b;
    for (int k = 0; k < 30 && !ok; k++) begin
      #1;
      if (reqReady[id]) ok = 1'b1;
      else @(negedge clk);
    end
    checkValue("accept", ok, 1);
    if (ok) sbQ.push_back(exp);
    @(negedge clk);
    reqValid[id] = 1'b0;
  endtask

  task automatic waitResp(input int expLat, input int clearAt);
    int lat;
    lat = 1;
    while (!rspValid && lat < 60) begin
      if (lat == clearAt) xeFault = 1'b0;
      @(negedge clk);
      lat++;
    end
    checkValue("latency", 8'(lat), 8'(expLat));
  endtask

  task automatic applyStimulus(input vec_t v);
    rsp_t e;
    e = '{v.id, v.expSum, v.expCarry, v.expErr};
    acceptReq(v.id, v.op, v.a, v.b, e);
    checkValue("alu_c", aluC, v.expC);
    if (v.op != 2'd3) checkValue("alu_par", aluPar, v.expPar);
    checkValue("busy", busy, 1);
    waitResp((v.op == 2'd3) ? 1 : SETTLE + 2, 0);
  endtask

  task automatic drain();
    @(negedge clk);
    for (int k = 0; k < 30 && sbQ.size() > 0; k++) @(negedge clk);
    checkValue("scoreboard_empty", 8'(sbQ.size()), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   grants;
    logic gid;
    logic expIds[3];
    rsp_t e;

    vecs[0] = '{1'b0, 2'd0, 3'd3, 3'd2, 3'd5, 1'b0, 1'b0, 3'b001, 1'b0};
    vecs[1] = '{1'b1, 2'd0, 3'd7, 3'd1, 3'd0, 1'b1, 1'b0, 3'b001, 1'b1};
    vecs[2] = '{1'b0, 2'd0, 3'd6, 3'd5, 3'd3, 1'b1, 1'b0, 3'b001, 1'b1};
    vecs[3] = '{1'b1, 2'd1, 3'd5, 3'd1, 3'd4, 1'b1, 1'b0, 3'b010, 1'b0};
    vecs[4] = '{1'b0, 2'd2, 3'd5, 3'd1, 3'd4, 1'b0, 1'b0, 3'b100, 1'b0};
    vecs[5] = '{1'b1, 2'd1, 3'd2, 3'd5, 3'd5, 1'b0, 1'b0, 3'b010, 1'b0};
    vecs[6] = '{1'b0, 2'd3, 3'd4, 3'd4, 3'd0, 1'b0, 1'b1, 3'b001, 1'b0};
    vecs[7] = '{1'b1, 2'd3, 3'd1, 3'd2, 3'd0, 1'b0, 1'b1, 3'b001, 1'b0};
    vecs[8] = '{1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'b001, 1'b1};

    reqValid = 2'b00;
    reqOp    = '0;
    reqA     = '0;
    reqB     = '0;
    rspReady = 1'b1;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    checkResetValues();
    rst = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i]);
    drain();

    // Response held stable while the consumer stalls.
    rspReady = 1'b0;
    acceptReq(1'b0, 2'd0, 3'd2, 3'd3, '{1'b0, 3'd5, 1'b0, 1'b0});
    waitResp(SETTLE + 2, 0);
    repeat (3) begin
      @(negedge clk);
      checkValue("hold_valid", rspValid, 1);
      checkValue("hold_sum", rspSum, 5);
      checkValue("hold_ready", reqReady, 0);
    end
    rspReady = 1'b1;
    drain();
    checkValue("hold_busy_after", busy, 0);

    // Round-robin with both requesters continuously valid, fresh pointer.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expIds   = '{1'b0, 1'b1, 1'b0};
    reqOp[0] = 2'd1; reqA[0] = 3'd5; reqB[0] = 3'd1;
    reqOp[1] = 2'd2; reqA[1] = 3'd5; reqB[1] = 3'd1;
    reqValid = 2'b11;
    grants   = 0;
    for (int c = 0; c < 60 && grants < 3; c++) begin
      #1;
      checkValue("rr_onehot", 8'(reqReady == 2'b11), 0);
      if (rspValid) checkValue("rr_no_grant_in_resp", reqReady, 0);
      if (|reqReady) begin
        gid = reqReady[1];
        checkValue("rr_grant_id", gid, expIds[grants]);
        e = expIds[grants] ? '{1'b1, 3'd4, 1'b0, 1'b0} : '{1'b0, 3'd4, 1'b1, 1'b0};
        sbQ.push_back(e);
        grants++;
      end
      @(negedge clk);
    end
    checkValue("rr_grants", 8'(grants), 3);
    reqValid = 2'b00;
    drain();

    // Single rail fault on the first check only: one retry, then clean.
    xeFault = 1'b1;
    acceptReq(1'b0, 2'd0, 3'd3, 3'd4, '{1'b0, 3'd7, 1'b0, 1'b0});
    waitResp(SETTLE + 2 + (SETTLE + 1), 3);
    xeFault = 1'b0;
    drain();

    // Permanent channel mismatch exhausts retries.
`ifdef FT_ALU_CTRL_FAULT_CNT_EN
    @(negedge clk);
    faultClr = 1'b1;
    @(negedge clk);
    faultClr = 1'b0;
    checkValue("fault_cnt_clr", faultCnt, 0);
`endif
    xyMismatch = 1'b1;
    acceptReq(1'b1, 2'd1, 3'd6, 3'd3, '{1'b1, 3'd3, 1'b1, 1'b1});
    waitResp(SETTLE + 2 + MAXR * (SETTLE + 1), 0);
    xyMismatch = 1'b0;
    drain();
`ifdef FT_ALU_CTRL_FAULT_CNT_EN
    checkValue("fault_cnt", faultCnt, 3);
`endif

    // Reset mid-ISSUE drops the in-flight response.
    acceptReq(1'b1, 2'd0, 3'd7, 3'd6, '{1'b1, 3'd5, 1'b1, 1'b0});
    checkValue("abort_busy", busy, 1);
    rst = 1'b1;
    #2;
    checkResetValues();
    sbQ.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkValue("abort_no_rsp", rspValid, 0);
    end
    acceptReq(1'b0, 2'd2, 3'd2, 3'd6, '{1'b0, 3'd4, 1'b1, 1'b0});
    waitResp(SETTLE + 2, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
